// File: rtl/ncl_pkg.sv
// ncl_pkg
// Shared types and helpers for the NCL multiplier bridge.
//   dual_rail_logic : one dual-rail bit {rail1, rail0}; NULL is {0,0}.
//   bridge_state_t  : bridge FSM states (IDLE, DATA, NULL, RECOVER).
//   dr_complete     : every bit of a dual-rail vector has exactly one rail high.
//   dr_null         : every rail of a dual-rail vector is low.
package ncl_pkg;

    localparam int OP_W = 3;
    localparam int P_W  = 6;

    typedef struct packed {
        logic rail1;
        logic rail0;
    } dual_rail_logic;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_NULL    = 2'd2,
        ST_RECOVER = 2'd3
    } bridge_state_t;

    function automatic logic dr_complete(input dual_rail_logic [P_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < P_W; i++) begin
            ok = ok & (v[i].rail1 ^ v[i].rail0);
        end
        return ok;
    endfunction

    function automatic logic dr_null(input dual_rail_logic [P_W-1:0] v);
        return (v == '0);
    endfunction

endpackage

// File: rtl/ncl_sync.sv
// ncl_sync
// Flop-chain synchroniser for one asynchronous bit, cleared by reset.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous input bit
//   q        : synchronised output (STAGES cycles of latency)
// STAGES must be at least 2.
module ncl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ncl_mult3_sync_bridge.sv
// ncl_mult3_sync_bridge
// Clocked front/back end for the 3x3 NCL multiplier. Binary operands arrive
// on a valid/ready port, are driven as dual-rail DATA/NULL wavefronts with the
// four-phase Ki/Ko handshake, and the synchronised dual-rail product is
// returned as a 6-bit binary value on a second valid/ready port.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high; valid, once raised by the producer, is
// held with stable data until that transfer.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b : operand port
//   out_valid/out_ready/out_p   : product port (single-entry buffer)
//   a_rail1/0, b_rail1/0        : registered dual-rail operands to multiplier
//   ncl_ki                      : registered Ki (1 = request DATA, 0 = NULL)
//   ncl_rst                     : registered multiplier reset
//   ncl_ko, p_rail1/0           : asynchronous Ko and dual-rail product
//   busy                        : FSM is not in IDLE
//   err_illegal                 : sticky, some product bit had both rails high
//   err_timeout                 : sticky, watchdog fired
//
// Build option: define NCL_MULT3_BRIDGE_TIMEOUT_EN to enable the DATA/NULL
// watchdog and the RECOVER path; otherwise err_timeout is tied low and the FSM
// waits indefinitely.
module ncl_mult3_sync_bridge
    import ncl_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_p,
    output logic [2:0] a_rail1,
    output logic [2:0] a_rail0,
    output logic [2:0] b_rail1,
    output logic [2:0] b_rail0,
    output logic       ncl_ki,
    output logic       ncl_rst,
    input  logic       ncl_ko,
    input  logic [5:0] p_rail1,
    input  logic [5:0] p_rail0,
    output logic       busy,
    output logic       err_illegal,
    output logic       err_timeout
);

    localparam int REC_W = $clog2(RECOVER_CYCLES + 1);

    // ---------------- synchronisers ----------------
    logic           ko_s;
    logic [P_W-1:0] pr1_s;
    logic [P_W-1:0] pr0_s;
    dual_rail_logic [P_W-1:0] p_dr;

    ncl_sync #(.STAGES(SYNC_STAGES)) u_sync_ko (
        .clk (clk),
        .rst (rst),
        .d   (ncl_ko),
        .q   (ko_s)
    );

    for (genvar i = 0; i < P_W; i++) begin : g_psync
        ncl_sync #(.STAGES(SYNC_STAGES)) u_sync_r1 (
            .clk (clk),
            .rst (rst),
            .d   (p_rail1[i]),
            .q   (pr1_s[i])
        );
        ncl_sync #(.STAGES(SYNC_STAGES)) u_sync_r0 (
            .clk (clk),
            .rst (rst),
            .d   (p_rail0[i]),
            .q   (pr0_s[i])
        );
        assign p_dr[i] = {pr1_s[i], pr0_s[i]};
    end

    logic p_complete;
    logic p_null;
    logic p_illegal;

    assign p_complete = dr_complete(p_dr);
    assign p_null     = dr_null(p_dr);
    assign p_illegal  = |(pr1_s & pr0_s);

    // ---------------- FSM ----------------
    bridge_state_t    state;
    bridge_state_t    state_n;
    logic [2:0]       a1_n, a0_n, b1_n, b0_n;
    logic             ki_n;
    logic             cap;
    logic             out_valid_n;
    logic             out_free;
    logic [REC_W-1:0] rec_cnt;

    assign out_free = !out_valid || out_ready;
    assign busy     = (state != ST_IDLE);

    // ncl_ki is low for the first cycle out of reset and after RECOVER entry;
    // gating on it keeps in_ready off in any cycle the multiplier sees Ki=0.
    assign in_ready = (state == ST_IDLE) && ncl_ki && ko_s && p_null && out_free;

`ifdef NCL_MULT3_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             tmo_fire;

    assign tmo_hit = ((state == ST_DATA) || (state == ST_NULL)) &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_n = state;
        a1_n    = a_rail1;
        a0_n    = a_rail0;
        b1_n    = b_rail1;
        b0_n    = b_rail0;
        ki_n    = ncl_ki;
        cap     = 1'b0;
`ifdef NCL_MULT3_BRIDGE_TIMEOUT_EN
        tmo_fire = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                ki_n = 1'b1;
                if (in_valid && in_ready) begin
                    a1_n    = in_a;
                    a0_n    = ~in_a;
                    b1_n    = in_b;
                    b0_n    = ~in_b;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                ki_n = 1'b1;
                // Without a free output slot DATA is simply held (backpressure).
                if (p_complete && !ko_s && out_free) begin
                    cap     = 1'b1;
                    a1_n    = '0;
                    a0_n    = '0;
                    b1_n    = '0;
                    b0_n    = '0;
                    ki_n    = 1'b0;
                    state_n = ST_NULL;
                end
            end
            ST_NULL: begin
                ki_n = 1'b0;
                if (p_null && ko_s) begin
                    ki_n    = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_RECOVER: begin
                a1_n = '0;
                a0_n = '0;
                b1_n = '0;
                b0_n = '0;
                ki_n = 1'b0;
                if (rec_cnt == REC_W'(RECOVER_CYCLES - 1)) begin
                    ki_n    = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
`ifdef NCL_MULT3_BRIDGE_TIMEOUT_EN
        // A normal transition on the same edge wins; the watchdog only fires
        // when the FSM would otherwise stay put.
        if (tmo_hit && (state_n == state)) begin
            tmo_fire = 1'b1;
            state_n  = ST_RECOVER;
            a1_n     = '0;
            a0_n     = '0;
            b1_n     = '0;
            b0_n     = '0;
            ki_n     = 1'b0;
        end
`endif
    end

    always_comb begin
        out_valid_n = out_valid;
        if (out_valid && out_ready) out_valid_n = 1'b0;
        if (cap)                    out_valid_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            a_rail1     <= '0;
            a_rail0     <= '0;
            b_rail1     <= '0;
            b_rail0     <= '0;
            ncl_ki      <= 1'b0;
            ncl_rst     <= 1'b1;
            out_valid   <= 1'b0;
            out_p       <= '0;
            err_illegal <= 1'b0;
            rec_cnt     <= '0;
        end else begin
            state       <= state_n;
            a_rail1     <= a1_n;
            a_rail0     <= a0_n;
            b_rail1     <= b1_n;
            b_rail0     <= b0_n;
            ncl_ki      <= ki_n;
            ncl_rst     <= (state_n == ST_RECOVER);
            out_valid   <= out_valid_n;
            err_illegal <= err_illegal | p_illegal;
            if (cap) begin
                out_p <= pr1_s;
            end
            if ((state == ST_RECOVER) && (state_n == ST_RECOVER)) begin
                rec_cnt <= rec_cnt + REC_W'(1);
            end else begin
                rec_cnt <= '0;
            end
        end
    end

`ifdef NCL_MULT3_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= err_timeout | tmo_fire;
            if ((state_n != state) || !((state == ST_DATA) || (state == ST_NULL))) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/ncl_mult3_sync_bridge.md
# ncl_mult3_sync_bridge

Synchronous front/back-end for the 3×3 NCL multiplier. It accepts binary operands on a valid/ready interface and drives them as dual-rail DATA/NULL wavefronts into the multiplier. It runs the four-phase Ki/Ko handshake, synchronises and completion-detects the dual-rail product, and returns a binary 6-bit product on a second valid/ready interface. It sits between the clocked test/system logic and the asynchronous multiplier, wired directly to the multiplier's flat rail ports.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop depth of every async-to-sync path (ncl_ko, p_rail1/0); legal values 2–4.
- TIMEOUT_CYCLES, 64: cycle limit for the watchdog; used only when the configuration macro is defined.
- RECOVER_CYCLES, 4: cycles ncl_rst is held during timeout recovery.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accept.
- in_a  in  3  unsigned operand A.
- in_b  in  3  unsigned operand B.
- out_valid  out  1  product valid.
- out_ready  in  1  product accept.
- out_p  out  6  unsigned product A×B.
- a_rail1, a_rail0  out  3 each  dual-rail A to multiplier.
- b_rail1, b_rail0  out  3 each  dual-rail B to multiplier.
- ncl_ki  out  1  Ki to multiplier; 1 = request DATA, 0 = request NULL.
- ncl_rst  out  1  multiplier reset.
- ncl_ko  in  1  Ko from multiplier; async.
- p_rail1, p_rail0  in  6 each  dual-rail product; async.
- busy  out  1  FSM not in IDLE.
- err_illegal  out  1  sticky; a product bit was seen with both rails high.
- err_timeout  out  1  sticky; watchdog fired.

## Operation
- All rail outputs and ncl_ki are registered. NULL means both rails are 0.
- Synchronised signals: ko_s, and the product rails pr1_s/pr0_s.
- Product complete: every bit has exactly one rail high.
- Product null: all 12 rails are 0.
- FSM states: IDLE, DATA, NULL, RECOVER.

State behaviour:
- IDLE
  - Inputs are NULL; ncl_ki=1.
  - in_ready=1 only when ko_s=1, the product is null, and out_valid=0 or out_ready=1.
  - On in_valid&in_ready, register the operands, drive DATA (rail1=bit, rail0=~bit) and go to DATA.
- DATA
  - Hold DATA; ncl_ki=1.
  - When the product is complete, ko_s=0, and the output buffer is free (out_valid=0, or out_ready=1 this cycle):
    - capture out_p[i]=pr1_s[i];
    - set out_valid;
    - drive NULL on the inputs and ncl_ki=0;
    - go to NULL.
  - If the output buffer is not free, stay in DATA with ncl_ki=1 (backpressure).
- NULL
  - Hold NULL; ncl_ki=0.
  - When the product is null and ko_s=1, set ncl_ki=1 and go to IDLE.
- RECOVER
  - ncl_rst=1; inputs are NULL; ncl_ki=0.
  - After RECOVER_CYCLES cycles, go to IDLE.
- Output buffer: one entry; out_valid clears on out_valid&out_ready. Capture and drain in the same cycle are allowed.
- err_illegal is set in any cycle where pr1_s[i]&pr0_s[i] for any bit. It is cleared only by rst and does not alter the FSM.

Reset (rst=1 on a clock edge), including mid-operation:
- State goes to IDLE.
- ncl_rst=1; all rails=0; ncl_ki=0; in_ready=0; out_valid=0; out_p=0; busy=0; err_*=0; synchronisers cleared.
- ncl_rst deasserts on the first edge with rst=0.
- Any in-flight result is discarded.

## Timing
- Operand accept edge = cycle 0. DATA is on the rails from cycle 1.
- Result capture happens no earlier than SYNC_STAGES cycles after the multiplier's final output rail and Ko settle. out_valid is high the cycle after capture.
- Minimum operand-to-operand interval: 2·SYNC_STAGES+3 cycles, with a zero-delay multiplier.
- in_ready is never asserted in the same cycle as ncl_ki=0.
- Rails change only from registers. The bridge never moves DATA→DATA or NULL→NULL without an intervening opposite phase.

## Configuration
- NCL_MULT3_BRIDGE_TIMEOUT_EN defined:
  - a counter runs in DATA and NULL and clears on every state change;
  - when it reaches TIMEOUT_CYCLES, set err_timeout, discard the result (out_valid untouched) and go to RECOVER.
- Not defined:
  - no counter and no RECOVER entry;
  - err_timeout is tied to 0;
  - the FSM waits indefinitely.

## Structure
- Shared package ncl_pkg:
  - dual_rail_logic typedef (relocated there);
  - state enum for this block;
  - helpers dr_complete and dr_null over a dual-rail vector.
- Sub-module ncl_sync: SYNC_STAGES-deep, reset-to-0 flop chain, instantiated per async bit.

## Test plan
- 5×3 with an ideal behavioural multiplier → out_p=6'd15; rails return to NULL; ncl_ki sequence 1→0→1.
- 7×7 back-to-back with 6×5, out_ready=1 → out_p=49 then 30, in order; no operand accepted while ncl_ki=0.
- 4×6 with out_ready=0 for 20 cycles → FSM holds DATA with ncl_ki=1; on release out_p=24 and the next operand is accepted.
- Multiplier model forces p_rail1[2]=p_rail0[2]=1 → err_illegal=1 and stays set until rst.
- rst pulsed during DATA of 3×3 → next cycle all rails 0, ncl_rst=1, out_valid=0; then 2×2 → out_p=4.
- Macro defined, ncl_ko stuck at 1 → err_timeout after TIMEOUT_CYCLES, ncl_rst high for 4 cycles, then 1×7 → out_p=7.
